// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    localparam int          DEPTH_DEFAULT    = 2;
    localparam logic [15:0] NOP_INSTR        = 16'h0000;

    // Outstanding/drop counters are wide enough for repeated redirects that
    // leave several generations of dropped requests in flight.
    localparam int CNT_W = 8;
    // Buffer pointer and occupancy widths cover the legal DEPTH range 2..4.
    localparam int PTR_W = 2;
    localparam int OCC_W = 3;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {addr, instr} prefetch buffer with flush. Pop and push may
// happen in the same cycle, including when the buffer is full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic             full,
    output logic             empty,
    output logic [OCC_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);

    fetch_entry_t     mem [2**PTR_W];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the buffer outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers returned
// instructions with their addresses, and handles redirects by flushing and
// discarding responses to requests made before the redirect.
//
// Handshake: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both 1; while valid is held without ready the address
// does not change unless br_taken redirects. Responses come back in request
// order, one per imem_resp_valid cycle. An instruction transfers downstream
// on a cycle where instr_valid is 1 and stall is 0.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [15:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [15:0] imem_resp_data,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        stall,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic        instr_valid
);

    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [15:0]      fetch_pc;
    logic [15:0]      resp_pc;     // address of the next non-dropped response
    logic [CNT_W-1:0] live_cnt;    // outstanding requests whose data is wanted
    logic [CNT_W-1:0] drop_cnt;    // outstanding requests to be discarded
    logic [CNT_W-1:0] live_nxt;
    logic [CNT_W-1:0] drop_nxt;
    logic [CNT_W:0]   occ_total;
    logic [OCC_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             req_fire;
    logic             resp_live;
    logic             buf_push;
    logic             buf_pop;
    fetch_entry_t     head;

    // Request gating, buffer push/pop and next counter values. Dropped
    // requests are always older than live ones, so a response retires a
    // dropped request first.
    always_comb begin
        occ_total      = (CNT_W + 1)'(fifo_count) + {1'b0, live_cnt};
        imem_req_valid = rst_n && !br_taken && (occ_total < DEPTH_C);
        req_fire       = imem_req_valid && imem_req_ready;
        resp_live      = imem_resp_valid && (drop_cnt == '0) && (live_cnt != '0);
        buf_pop        = !fifo_empty && !stall && !br_taken;
        buf_push       = resp_live && !br_taken && (!fifo_full || buf_pop);
        live_nxt       = live_cnt;
        drop_nxt       = drop_cnt;
        if (br_taken) begin
            live_nxt = '0;
            drop_nxt = drop_cnt + live_cnt + CNT_W'(req_fire);
            if (imem_resp_valid && (drop_nxt != '0)) drop_nxt = drop_nxt - CNT_W'(1);
        end else begin
            if (imem_resp_valid) begin
                if (drop_cnt != '0)      drop_nxt = drop_cnt - CNT_W'(1);
                else if (live_cnt != '0) live_nxt = live_cnt - CNT_W'(1);
            end
            if (req_fire) live_nxt = live_nxt + CNT_W'(1);
        end
    end

    // Fetch/response address tracking and outstanding request bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            live_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            live_cnt <= live_nxt;
            drop_cnt <= drop_nxt;
            if (br_taken) begin
                fetch_pc <= br_target;
                resp_pc  <= br_target;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 16'd1;
                if (buf_push) resp_pc  <= resp_pc + 16'd1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (buf_push),
        .push_data('{addr: resp_pc, instr: imem_resp_data}),
        .pop      (buf_pop),
        .flush    (br_taken),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign imem_req_addr = fetch_pc;
    assign instr_valid   = !fifo_empty;
    assign instr         = fifo_empty ? NOP_INSTR : head.instr;
    assign pc            = fifo_empty ? 16'h0000 : head.addr;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, prefetch buffer entries; legal range 2..4.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port imem_req_valid  output  1  fetch request valid.
REQ-006 Port imem_req_addr  output  16  word address of request.
REQ-007 Port imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 Port imem_resp_valid  input  1  instruction word returned this cycle; in-order, at least 1 cycle after acceptance.
REQ-009 Port imem_resp_data  input  16  returned instruction word.
REQ-010 Port br_taken  input  1  redirect request from execute stage.
REQ-011 Port br_target  input  16  redirect address, valid when br_taken=1.
REQ-012 Port stall  input  1  downstream cannot consume instr this cycle.
REQ-013 Port instr  output  16  instruction to decode.
REQ-014 Port pc  output  16  address of instr.
REQ-015 Port instr_valid  output  1  instr/pc valid.

Function
REQ-016 Request accepted when imem_req_valid && imem_req_ready; fetch_pc then increments by 1, wrapping 16'hFFFF -> 16'h0000.
REQ-017 imem_req_addr SHALL equal fetch_pc; imem_req_valid SHALL be 1 only when (buffer occupancy + live outstanding requests) < DEPTH and br_taken=0.
REQ-018 imem_req_valid/imem_req_addr SHALL stay stable while valid && !ready unless br_taken asserts.
REQ-019 Non-dropped response SHALL be written into buffer tail with its address; buffer never overflows by REQ-017.
REQ-020 instr/pc/instr_valid SHALL reflect buffer head; empty buffer drives instr=16'h0000, pc=16'h0000, instr_valid=0.
REQ-021 Head popped when instr_valid && !stall; with stall=1 instr/pc/instr_valid SHALL hold.
REQ-022 Response arriving while buffer has one free slot and head popped in the same cycle SHALL be accepted (simultaneous push/pop).
REQ-023 On br_taken=1: buffer flushed, fetch_pc <= br_target, all requests outstanding at end of that cycle (including one accepted that cycle) marked dropped, response arriving that cycle discarded.
REQ-024 Dropped responses SHALL be counted down and discarded; no buffer write until drop count reaches 0.
REQ-025 First cycle after br_taken: instr_valid=0; first request to br_target may issue that cycle.
REQ-026 br_taken overrides stall; back-to-back br_taken cycles: last target wins, drop counts accumulate.
REQ-027 Response with no outstanding request is a protocol error; behaviour unspecified, flagged by bench assertion.

Reset
REQ-028 During rst_n=0: fetch_pc=RESET_PC, buffer empty, outstanding=0, drop count=0, imem_req_valid=0, instr_valid=0, instr=16'h0000, pc=16'h0000.
REQ-029 Reset mid-operation discards all in-flight and buffered instructions; responses to pre-reset requests arriving after release are memory's responsibility to suppress.
REQ-030 First request SHALL be offered the first cycle after rst_n deasserts.

Structure
REQ-031 Shared package fetch_pkg holds RESET_PC default, DEPTH default, NOP_INSTR=16'h0000, and counter widths.
REQ-032 One sub-module fetch_fifo: DEPTH-entry {addr,instr} FIFO with push, pop, flush, full, empty, count.

Verification
REQ-033 Reset release, ready=1, 1-cycle latency, stall=0 -> pc sequence 0,1,2,3 with matching instr, one per cycle after fill.
REQ-034 stall=1 for 5 cycles with buffer full -> instr/pc held, imem_req_valid=0, no loss; resume yields contiguous pc.
REQ-035 2 outstanding, br_taken with br_target=16'h0040 -> both later responses dropped, next valid pc=16'h0040.
REQ-036 imem_req_ready=0 for 3 cycles -> addr stable at same value; no instr_valid gaps beyond memory latency afterwards.
REQ-037 fetch_pc at 16'hFFFF -> next request addr 16'h0000, pc outputs FFFF then 0000.
REQ-038 br_taken asserted with stall=1 and response in same cycle -> flush, response dropped, next pc = br_target.
